// File: rtl/alu_selftest_gen.sv
// Exhaustive on-board self-test for an N-bit registered add/sub unit: sweeps {b,a,op_code,c_in},
// checks dut_q after LAT clocks, counts mismatches. Define STOP_ON_ERR_EN to halt on the first mismatch.
`timescale 1ns/1ps
module alu_selftest_gen #(
    parameter int N     = 8,
    parameter int LAT   = 1,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     dut_q,
    output logic [N-1:0]     a,
    output logic [N-1:0]     b,
    output logic             c_in,
    output logic             op_code,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2*N+1:0]   fail_vec,
    output logic [N-1:0]     fail_q
);
    localparam int VW = 2*N + 2;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q;
    logic [VW-1:0]    vec_q;
    logic [CW-1:0]    drain_q;
    logic [LAT-1:0]   vld_pipe_q;
    logic [N-1:0]     exp_pipe_q [LAT];
    logic [VW-1:0]    vec_pipe_q [LAT];
    logic [ERR_W-1:0] err_q;
    logic [VW-1:0]    fvec_q;
    logic [N-1:0]     fq_q;
    logic             busy_q, done_q, pass_q;

    logic             pipe_vld, mismatch, first_err;
    logic [ERR_W-1:0] err_d;

    // Subtract is a + ~b + c_in, so c_in=0 yields a-b-1.
    function automatic logic [N-1:0] ref_result(input logic [VW-1:0] v);
        logic [N-1:0] va, vb, vc;
        va = v[N+1:2];
        vb = v[VW-1:N+2];
        vc = N'(v[0]);
        return v[1] ? (va + ~vb + vc) : (va + vb + vc);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    always_comb begin
        pipe_vld  = vld_pipe_q[LAT-1] && ((state_q == S_RUN) || (state_q == S_DRAIN));
        mismatch  = pipe_vld && (dut_q != exp_pipe_q[LAT-1]);
        first_err = mismatch && (err_q == '0);
        err_d     = mismatch ? sat_inc(err_q) : err_q;
    end

    // Data side of the delay line carries no reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        exp_pipe_q[0] <= ref_result(vec_q);
        vec_pipe_q[0] <= vec_q;
        for (int i = 1; i < LAT; i++) begin
            exp_pipe_q[i] <= exp_pipe_q[i-1];
            vec_pipe_q[i] <= vec_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            drain_q    <= '0;
            vld_pipe_q <= '0;
            err_q      <= '0;
            fvec_q     <= '0;
            fq_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            for (int i = 1; i < LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            vld_pipe_q[0] <= (state_q == S_RUN);
            err_q <= err_d;
            if (first_err) begin
                fvec_q <= vec_pipe_q[LAT-1];
                fq_q   <= dut_q;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        vec_q      <= '0;
                        drain_q    <= '0;
                        vld_pipe_q <= '0;
                        err_q      <= '0;
                        fvec_q     <= '0;
                        fq_q       <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (&vec_q) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end else begin
                        vec_q <= vec_q + VW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == CW'(LAT - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        drain_q <= drain_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef STOP_ON_ERR_EN
            // Abort: freeze stimulus and drop whatever is still in flight.
            if (mismatch) begin
                state_q    <= S_DONE;
                vec_q      <= vec_q;
                vld_pipe_q <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pass_q     <= 1'b0;
            end
`endif
        end
    end

    assign {b, a, op_code, c_in} = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;
    assign fail_q    = fq_q;
endmodule

// File: tb/tb_alu_selftest_gen.sv
// Bench for alu_selftest_gen (N=4): a behavioural add/sub DUT with injectable faults, and a
// sweep-level reference model that predicts error count, first failure and completion time.
`timescale 1ns/1ps
module tb_alu_selftest_gen;
    localparam int N     = 4;
    localparam int ERR_W = 16;
    localparam int LAT   = 1;
    localparam int VW    = 2*N + 2;
    localparam int NV    = 1 << VW;
    localparam int M     = 1 << N;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, lat2_sel = 1'b0;
    logic [N-1:0]     a1, b1, q1, fq1, a2, b2, q2, fq2;
    logic             c1, op1, busy1, done1, pass1, c2, op2, busy2, done2, pass2;
    logic [ERR_W-1:0] err1, err2;
    logic [VW-1:0]    fv1, fv2;
    logic [N-1:0]     d1a, d1b, d2a, d2b;

    int stuck0 = 0, stuck1 = 0, flip_idx = -1, flip_mask = 0;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_selftest_gen #(.N(N), .LAT(LAT), .ERR_W(ERR_W)) u_gen (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_q(q1),
        .a(a1), .b(b1), .c_in(c1), .op_code(op1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1), .fail_q(fq1));

    alu_selftest_gen #(.N(N), .LAT(2), .ERR_W(ERR_W)) u_gen_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_q(q2),
        .a(a2), .b(b2), .c_in(c2), .op_code(op2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fv2), .fail_q(fq2));

    // Arithmetic meaning of a vector: add, or a-b (c=1) / a-b-1 (c=0), wrapped to N bits.
    function automatic int golden(input int v);
        int av, bv, op, c, r;
        av = (v >> 2) % M;
        bv = (v >> (N + 2)) % M;
        op = (v >> 1) & 1;
        c  = v & 1;
        r  = op ? (av - bv - 1 + c) : (av + bv + c);
        return ((r % M) + M) % M;
    endfunction

    function automatic int faulty(input int g, input int v);
        int q;
        q = (g & ~stuck0) | stuck1;
        if (v == flip_idx) q = q ^ flip_mask;
        return q & (M - 1);
    endfunction

    always @(posedge clk) begin
        d1a <= N'(faulty(golden(int'({b1, a1, op1, c1})), int'({b1, a1, op1, c1})));
        d1b <= d1a;
        d2a <= N'(golden(int'({b2, a2, op2, c2})));
        d2b <= d2a;
    end
    assign q1 = lat2_sel ? d1b : d1a;
    assign q2 = d2b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(output int cnt, output int fv, output int fq);
        cnt = 0; fv = 0; fq = 0;
        for (int v = 0; v < NV; v++) begin
            int g, q;
            g = golden(v);
            q = faulty(g, v);
            if (q != g) begin
                if (cnt == 0) begin fv = v; fq = q; end
                cnt++;
            end
        end
    endtask

    // Pulse start into edge E0; k counts edges after E0, sampled 1ns after each.
    task automatic sweep(input int pulse_at, output int done_at, output int busy_cnt,
                         output logic [ERR_W-1:0] err_at0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_at = -1; busy_cnt = 0; err_at0 = err1;
        for (int k = 0; k < NV + 50; k++) begin
            if (k > 0) begin @(posedge clk); #1; start = 1'b0; end
            if (busy1) busy_cnt++;
            if (done1) begin done_at = k; break; end
            start = (k + 1 == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int pulse_at);
        int cnt, fv, fq, done_at, busy_cnt, exp_done, exp_err;
        logic [ERR_W-1:0] err_at0;
        model(cnt, fv, fq);
`ifdef STOP_ON_ERR_EN
        exp_done = (cnt > 0) ? fv + 1 + LAT : NV + LAT;
        exp_err  = (cnt > 0) ? 1 : 0;
`else
        exp_done = NV + LAT;
        exp_err  = cnt;
`endif
        sweep(pulse_at, done_at, busy_cnt, err_at0);
        check({tag, "_cleared"}, err_at0, 0);
        check({tag, "_done_at"}, done_at, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done);
        check({tag, "_err_count"}, err1, exp_err);
        check({tag, "_pass"}, pass1, (cnt == 0));
        check({tag, "_fail_vec"}, fv1, fv);
        check({tag, "_fail_q"}, fq1, fq);
    endtask

    initial begin
        int found, done_at, busy_cnt;
        logic [ERR_W-1:0] err_at0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", err1, 0);
        check("rst_fail_vec", fv1, 0);
        check("rst_stim", {b1, a1, op1, c1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_and_check("golden", -1);

        stuck0 = 1;
        run_and_check("stuck0", -1);
`ifndef STOP_ON_ERR_EN
        check("stuck0_err512", err1, 512);
`endif
        check("stuck0_vec1", fv1, 1);
        check("stuck0_q0", fq1, 0);
        stuck0 = 0;

        run_and_check("restart", -1);

        repeat (3) @(posedge clk);
        #1;
        lat2_sel = 1'b1;
        sweep(-1, done_at, busy_cnt, err_at0);
        check("lat_mismatch_pass", pass1, 0);
        check("lat_mismatch_err_nz", (err1 != 0), 1);
        @(posedge clk); #1;
        check("lat2_done", done2, 1);
        check("lat2_pass", pass2, 1);
        check("lat2_err", err2, 0);
        lat2_sel = 1'b0;

        run_and_check("midstart", 500);

`ifndef STOP_ON_ERR_EN
        stuck0 = 1;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if ({b1, a1, op1, c1} == VW'(300)) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("midreset_reached", found, 1);
`ifndef STOP_ON_ERR_EN
        check("midreset_err_nz", (err1 != 0), 1);
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", busy1, 0);
        check("midreset_done", done1, 0);
        check("midreset_err", err1, 0);
        check("midreset_fail_vec", fv1, 0);
        check("midreset_fail_q", fq1, 0);
        check("midreset_stim", {b1, a1, op1, c1}, 0);
        rst_n = 1'b1;
        stuck0 = 0;
        @(posedge clk); #1;
        run_and_check("after_reset", -1);

        for (int r = 0; r < 4; r++) begin
            stuck0    = ($urandom_range(0, 2) == 0) ? (1 << $urandom_range(0, N - 1)) : 0;
            stuck1    = ($urandom_range(0, 2) == 0) ? (1 << $urandom_range(0, N - 1)) : 0;
            flip_idx  = $urandom_range(0, NV - 1);
            flip_mask = $urandom_range(0, M - 1);
            run_and_check("random", -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
